// File: rtl/fft8_pkg.sv
// Shared definitions for the 8-point radix-2 DIT FFT controller:
// FSM state type, twiddle scaling constants and the load-address bit reversal.
package fft8_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    CALC   = 2'd1,
    UNLOAD = 2'd2
  } state_t;

  // cos(pi/4) approximated as 181/256
  localparam int TW_C     = 181;
  localparam int TW_SHIFT = 8;

  function automatic logic [2:0] bitrev3(input logic [2:0] n);
    return {n[0], n[1], n[2]};
  endfunction

endpackage

// File: rtl/fft8_bf_unit.sv
// Combinational radix-2 butterfly: x = A + Wt*B, y = A - Wt*B, all at W bits
// with wrap-around; the four 8-point twiddles are realised with swaps and one constant multiply.
module fft8_bf_unit
  import fft8_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a_r,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_r,
  input  logic [W-1:0] b_i,
  input  logic [1:0]   tw,
  output logic [W-1:0] x_r,
  output logic [W-1:0] x_i,
  output logic [W-1:0] y_r,
  output logic [W-1:0] y_i
);

  // Operand is sign-extended before the multiply so the shift is arithmetic
  function automatic logic [W-1:0] cmul(input logic [W-1:0] v);
    logic signed [W+8:0] p;
    p = $signed({{9{v[W-1]}}, v}) * $signed((W+9)'(TW_C));
    return W'(p >>> TW_SHIFT);
  endfunction

  logic [W-1:0] sum_pp, diff_ir, sum_nn, neg_r;
  logic [W-1:0] w_r, w_i;

  assign sum_pp  = b_r + b_i;
  assign diff_ir = b_i - b_r;
  assign sum_nn  = W'(0) - b_r - b_i;
  assign neg_r   = W'(0) - b_r;

  always_comb begin
    w_r = b_r;
    w_i = b_i;
    case (tw)
      2'd1: begin
        w_r = cmul(sum_pp);
        w_i = cmul(diff_ir);
      end
      2'd2: begin
        w_r = b_i;
        w_i = neg_r;
      end
      2'd3: begin
        w_r = cmul(diff_ir);
        w_i = cmul(sum_nn);
      end
      default: begin
        w_r = b_r;
        w_i = b_i;
      end
    endcase
  end

  assign x_r = a_r + w_r;
  assign x_i = a_i + w_i;
  assign y_r = a_r - w_r;
  assign y_i = a_i - w_i;

endmodule

// File: rtl/fft8_ctrl.sv
// 8-point in-place FFT: loads samples in bit-reversed order, runs 12 butterflies
// (one per cycle) and streams bins X[0]..X[7] out with valid/ready handshakes.
module fft8_ctrl
  import fft8_pkg::*;
#(
  parameter int N = 4,
  localparam int W = 2**N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_r,
  input  logic [W-1:0] in_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_r,
  output logic [W-1:0] out_i,
  output logic         out_last,
  output logic         busy
);

  state_t       state;
  logic [2:0]   load_cnt;
  logic [3:0]   op_cnt;
  logic [2:0]   out_cnt;
  logic [W-1:0] mem_r [8];
  logic [W-1:0] mem_i [8];

  logic [1:0]   stage;
  logic [1:0]   k;
  logic [2:0]   addr_a, addr_b;
  logic [1:0]   tw;
  logic [W-1:0] x_r, x_i, y_r, y_i;
  logic         accept;

  assign accept = in_valid && in_ready && (state == LOAD);
  assign stage  = op_cnt[3:2];
  assign k      = op_cnt[1:0];

  // Butterfly pair spacing doubles each stage; twiddle step halves
  always_comb begin
    addr_a = {k, 1'b0};
    addr_b = {k, 1'b1};
    tw     = 2'd0;
    case (stage)
      2'd1: begin
        addr_a = {k[1], 1'b0, k[0]};
        addr_b = {k[1], 1'b1, k[0]};
        tw     = {k[0], 1'b0};
      end
      2'd2: begin
        addr_a = {1'b0, k};
        addr_b = {1'b1, k};
        tw     = k;
      end
      default: begin
        addr_a = {k, 1'b0};
        addr_b = {k, 1'b1};
        tw     = 2'd0;
      end
    endcase
  end

  fft8_bf_unit #(.W(W)) u_bf (
    .a_r (mem_r[addr_a]),
    .a_i (mem_i[addr_a]),
    .b_r (mem_r[addr_b]),
    .b_i (mem_i[addr_b]),
    .tw  (tw),
    .x_r (x_r),
    .x_i (x_i),
    .y_r (y_r),
    .y_i (y_i)
  );

  // Sample buffer has no reset: its contents are meaningless until a frame is loaded
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_r[bitrev3(load_cnt)] <= in_r;
      mem_i[bitrev3(load_cnt)] <= in_i;
    end else if (state == CALC) begin
      mem_r[addr_a] <= x_r;
      mem_i[addr_a] <= x_i;
      mem_r[addr_b] <= y_r;
      mem_i[addr_b] <= y_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      load_cnt  <= 3'd0;
      op_cnt    <= 4'd0;
      out_cnt   <= 3'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            load_cnt <= load_cnt + 3'd1;
            if (load_cnt == 3'd7) begin
              state    <= CALC;
              op_cnt   <= 4'd0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        CALC: begin
          op_cnt <= op_cnt + 4'd1;
          // X[0] is final after stage 2 op 0, so it can be registered on the last op edge
          if (op_cnt == 4'd11) begin
            state     <= UNLOAD;
            out_cnt   <= 3'd0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            out_r     <= mem_r[0];
            out_i     <= mem_i[0];
          end
        end
        UNLOAD: begin
          if (out_ready) begin
            if (out_cnt == 3'd7) begin
              state     <= LOAD;
              load_cnt  <= 3'd0;
              out_cnt   <= 3'd0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              out_r     <= '0;
              out_i     <= '0;
            end else begin
              out_cnt  <= out_cnt + 3'd1;
              out_r    <= mem_r[out_cnt + 3'd1];
              out_i    <= mem_i[out_cnt + 3'd1];
              out_last <= (out_cnt == 3'd6);
            end
          end
        end
        default: begin
          state    <= LOAD;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fft8_ctrl.md
FFT8_CTRL -- requirements
Module: fft8_ctrl

Interface
REQ-001 SHALL have parameter N, default 4; datapath word width W = 2**N bits, two's complement.
REQ-002 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, input sample present.
REQ-005 SHALL have port in_ready, output, 1, block accepts a sample this cycle.
REQ-006 SHALL have ports in_r and in_i, input, W each, real and imaginary parts of the input sample.
REQ-007 SHALL have port out_valid, output, 1, output bin present.
REQ-008 SHALL have port out_ready, input, 1, consumer accepts a bin.
REQ-009 SHALL have ports out_r and out_i, output, W each, real and imaginary parts of the bin.
REQ-010 SHALL have port out_last, output, 1, asserted with bin X[7].
REQ-011 SHALL have port busy, output, 1, high in CALC and UNLOAD.

Function
REQ-012 SHALL implement FSM states LOAD, CALC and UNLOAD; reset state is LOAD.
REQ-013 SHALL assert in_ready only in LOAD; a beat is accepted when in_valid and in_ready are both high.
REQ-014 SHALL store accepted sample n (n = 0..7, arrival order) in an 8-entry complex buffer at address bitrev3(n).
REQ-015 SHALL transition LOAD -> CALC on the edge that accepts sample 7.
REQ-016 SHALL perform one radix-2 DIT butterfly per cycle in CALC: 12 operations, in order stage s = 0..2, op k = 0..3.
REQ-017 SHALL address each operation as h = 2**s, j = k mod h, a = (k / h)*2h + j, b = a + h, twiddle index t = j*(4 >> s).
REQ-018 SHALL write buf[a] = A + Wt*B and buf[b] = A - Wt*B in the same cycle, where A = buf[a] and B = buf[b].
REQ-019 SHALL compute Wt*B, with B = (br, bi), as: t=0 -> (br, bi); t=1 -> (c(br+bi), c(bi-br)); t=2 -> (bi, -br); t=3 -> (c(bi-br), c(-br-bi)).
REQ-020 SHALL define c(x) = (x*181) arithmetic-shifted right by 8, truncated to W bits, with the intermediate sum x held at W bits.
REQ-021 SHALL perform all additions and subtractions at W bits with wrap-around; no saturation, no scaling.
REQ-022 SHALL transition CALC -> UNLOAD on the edge completing op 12; out_valid therefore rises exactly 12 cycles after the edge that accepted sample 7.
REQ-023 SHALL present bins in natural order X[0]..X[7] from buf[0..7] in UNLOAD, advancing only on out_valid and out_ready both high.
REQ-024 SHALL hold out_r, out_i and out_last stable while out_valid is high and out_ready is low.
REQ-025 SHALL transition UNLOAD -> LOAD on the handshake of X[7]; in_ready rises the following cycle.
REQ-026 SHALL ignore in_valid outside LOAD, and SHALL ignore out_ready outside UNLOAD.

Reset
REQ-027 SHALL, on rst assertion at any time including mid-CALC or mid-UNLOAD, force state LOAD, all counters 0, in_ready 1, out_valid 0, out_last 0, busy 0, out_r/out_i 0; buffer contents are don't-care.
REQ-028 SHALL accept sample 0 on the first clk edge after rst deasserts, provided in_valid is high.

Structure
REQ-029 SHALL place in shared package fft8_pkg: the state enum, the constant TW_C = 181, the shift constant 8, and the bitrev3 function.
REQ-030 SHALL isolate the butterfly arithmetic (A, B, t -> two outputs) in combinational sub-module fft8_bf_unit; sequencing, buffer and handshakes stay in fft8_ctrl.

Verification
REQ-031 SHALL cover DC input: N=4, all 8 samples (100, 0) -> X[0] = (800, 0), X[1..7] = (0, 0), out_last only on X[7].
REQ-032 SHALL cover impulse: x[1] = (256, 0), all others 0 -> X[0] = (256, 0), X[1] = (181, -181), X[2] = (0, -256), X[3] = (-181, -181), X[4] = (-256, 0).
REQ-033 SHALL cover backpressure: out_ready low for 5 cycles on X[3] -> X[3] is held stable, no bin is lost or duplicated, and in_ready stays 0.
REQ-034 SHALL cover input gaps: in_valid toggled randomly during LOAD -> result identical to the gap-free run; out_valid rises exactly 12 cycles after the 8th accept.
REQ-035 SHALL cover reset mid-CALC (op 6): rst pulse -> in_ready = 1, out_valid = 0 immediately; a following DC frame yields the correct result.
REQ-036 SHALL cover wrap: all samples (8192, 0) at W = 16 -> X[0] = (0, 0) (65536 mod 2**16), no X/Z on outputs.
